arcade_input_cond: RTL



---
 rtl/arcade_input_pkg.sv | 20 ++
 rtl/input_debounce.sv | 54 +++++
 rtl/arcade_input_cond.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared types and constants for the arcade control conditioner.
// Latency: none (definitions only).
// Backpressure: none.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } coin_state_t;

    localparam int BTN_COIN   = 0;
    localparam int BTN_START1 = 1;
    localparam int BTN_START2 = 2;
    localparam int BTN_FIRE   = 3;
    localparam int BTN_LEFT   = 4;
    localparam int BTN_RIGHT  = 5;
    localparam int NUM_BTN    = 6;

endpackage

// File: rtl/input_debounce.sv
// One control bit: 2-FF synchroniser, tick-counted debounce, stable level register.
// Latency: 2 cycles to sync, then DEBOUNCE_TICKS ticks of disagreement before stable follows.
// Backpressure: none; raw input is free-running.
module input_debounce #(
    parameter int DEBOUNCE_TICKS = 5
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic raw_i,
    input  logic tick_i,
    output logic stable_o
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

    logic       meta_q;
    logic       sync_q;
    logic       stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;

    // Count ticks of disagreement; any agreement wipes the count so short glitches die out.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Synchroniser chain plus debounce state.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Conditions six cabinet controls for the game core: debounce, L/R resolve, coin pulse shaping.
// Latency: sync 2 + debounce ticks + 1 output register; coin pulse starts 2 cycles after stable rise.
// Backpressure: none; up to 3 coins queue during a pulse, further presses are dropped.
module arcade_input_cond
    import arcade_input_pkg::*;
#(
    parameter int TICK_DIV        = 10000,
    parameter int DEBOUNCE_TICKS  = 5,
    parameter int COIN_HIGH_TICKS = 80,
    parameter int COIN_LOW_TICKS  = 80
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic               coin,
    output logic               sel1_n,
    output logic               sel2_n,
    output logic               fire_n,
    output logic               left_n,
    output logic               right_n,
    output logic [1:0]         coin_pending,
    output logic               coin_busy
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     HIGH_LAST  = 16'(COIN_HIGH_TICKS - 1);
    localparam logic [15:0]     LOW_LAST   = 16'(COIN_LOW_TICKS - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [NUM_BTN-1:0] stable;

    logic               sel1_n_q, sel2_n_q, fire_n_q, left_n_q, right_n_q;
    logic               coin_prev_q;
    logic               coin_rise;
    logic               dequeue;
    logic [1:0]         pending_q, pending_d;
    coin_state_t        state_q;
    logic [15:0]        timer_q;
    logic               coin_q;

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Free-running timebase shared by all debouncers and the coin timer.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        input_debounce #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_db (
            .clk_sys (clk_sys),
            .rst_n   (rst_n),
            .raw_i   (btn_raw[i]),
            .tick_i  (tick),
            .stable_o(stable[i])
        );
    end

    // Core-polarity outputs; pressing both directions reads as neither.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sel1_n_q  <= 1'b1;
            sel2_n_q  <= 1'b1;
            fire_n_q  <= 1'b1;
            left_n_q  <= 1'b1;
            right_n_q <= 1'b1;
        end else begin
            sel1_n_q  <= ~stable[BTN_START1];
            sel2_n_q  <= ~stable[BTN_START2];
            fire_n_q  <= ~stable[BTN_FIRE];
            left_n_q  <= ~(stable[BTN_LEFT] & ~stable[BTN_RIGHT]);
            right_n_q <= ~(stable[BTN_RIGHT] & ~stable[BTN_LEFT]);
        end
    end

    assign coin_rise = stable[BTN_COIN] & ~coin_prev_q;
    assign dequeue   = (state_q == IDLE) && (pending_q != 2'd0);

    // Queue count: a rise and a dequeue in the same cycle cancel out.
    always_comb begin
        pending_d = pending_q;
        if (coin_rise && !dequeue) begin
            if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
        end else if (dequeue && !coin_rise) begin
            pending_d = pending_q - 2'd1;
        end
    end

    // Coin edge history and queued coin count.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            coin_prev_q <= 1'b0;
            pending_q   <= 2'd0;
        end else begin
            coin_prev_q <= stable[BTN_COIN];
            pending_q   <= pending_d;
        end
    end

    // Coin pulse shaper: fixed high time then fixed low gap, counted in ticks.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            coin_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q != 2'd0) begin
                        state_q <= HIGH;
                        coin_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (timer_q == HIGH_LAST) begin
                            state_q <= GAP;
                            coin_q  <= 1'b0;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (timer_q == LOW_LAST) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    coin_q  <= 1'b0;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign coin         = coin_q;
    assign coin_busy    = (state_q != IDLE);
    assign coin_pending = pending_q;
    assign sel1_n       = sel1_n_q;
    assign sel2_n       = sel2_n_q;
    assign fire_n       = fire_n_q;
    assign left_n       = left_n_q;
    assign right_n      = right_n_q;

endmodule
